// File: rtl/fp_add_sequencer_if.sv
// Host-side handshake bundle for fp_add_sequencer: start/operands in, busy/valid/result/flags out.
`timescale 1ns/1ps
interface fp_add_sequencer_if;
  logic        Inicio;
  logic [31:0] Op_A;
  logic [31:0] Op_B;
  logic        Ocupado;
  logic        Valido;
  logic [31:0] Resultado;
  logic        Overflow;
  logic        Invalido;

  modport master (
    output Inicio, Op_A, Op_B,
    input  Ocupado, Valido, Resultado, Overflow, Invalido
  );

  modport slave (
    input  Inicio, Op_A, Op_B,
    output Ocupado, Valido, Resultado, Overflow, Invalido
  );
endinterface

// File: rtl/fp_add_sequencer.sv
// Multi-cycle IEEE-754 single-precision add/sub controller driving an external
// sign-magnitude mantissa Adder: unpack, align, add, normalize, round, pack.
`timescale 1ns/1ps
module fp_add_sequencer #(
  parameter logic [31:0] NAN_CANON = 32'h7FC00000
) (
  input  logic                clk,
  input  logic                rst_n,
  fp_add_sequencer_if.slave   bus,
  output logic                SignoA_o,
  output logic                SignoB_o,
  output logic [25:0]         Mantissa_A_o,
  output logic [25:0]         Mantissa_B_o,
  input  logic [26:0]         Suma_resul_i,
  input  logic                Signo_sum_i
);

  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE} state_t;

  state_t      state;
  logic [31:0] op_a, op_b;
  logic        sa, sb;
  logic [7:0]  ea, eb;
  logic [25:0] ma, mb;
  logic        sticky;
  logic [8:0]  exp_w;
  logic [26:0] sum;
  logic        sgn;
  logic [31:0] res_w;
  logic        ovf_w, inv_w;

  // Special-operand classification of the captured operands
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special;
  logic [31:0] spec_res;
  logic        spec_inv;
  always_comb begin
    a_nan   = (op_a[30:23] == 8'hFF) && (op_a[22:0] != '0);
    b_nan   = (op_b[30:23] == 8'hFF) && (op_b[22:0] != '0);
    a_inf   = (op_a[30:23] == 8'hFF) && (op_a[22:0] == '0);
    b_inf   = (op_b[30:23] == 8'hFF) && (op_b[22:0] == '0);
    a_zero  = (op_a[30:23] == '0);
    b_zero  = (op_b[30:23] == '0);
    special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
    spec_inv = 1'b0;
    if (a_nan || b_nan) begin
      spec_res = NAN_CANON;
      spec_inv = 1'b1;
    end else if (a_inf && b_inf && (op_a[31] != op_b[31])) begin
      spec_res = NAN_CANON;
      spec_inv = 1'b1;
    end else if (a_inf) begin
      spec_res = op_a;
    end else if (b_inf) begin
      spec_res = op_b;
    end else if (a_zero && b_zero) begin
      spec_res = {op_a[31] & op_b[31], 31'b0};
    end else if (a_zero) begin
      spec_res = op_b;
    end else begin
      spec_res = op_a;
    end
  end

  // Single-cycle alignment of the smaller-exponent mantissa with sticky collection
  logic        a_big;
  logic [7:0]  diff;
  logic [25:0] m_small, al_mant;
  logic [51:0] wide;
  logic        al_sticky;
  always_comb begin
    a_big   = (ea >= eb);
    diff    = a_big ? (ea - eb) : (eb - ea);
    m_small = a_big ? mb : ma;
    wide    = {m_small, 26'b0} >> diff;
    if (diff >= 8'd26) begin
      al_mant   = '0;
      al_sticky = |m_small;
    end else begin
      al_mant   = wide[51:26];
      al_sticky = |wide[25:0];
    end
  end

  // Round-to-nearest-even on the normalized sum
  logic        inc;
  logic [24:0] rnd;
  logic [8:0]  r_exp;
  logic [22:0] r_frac;
  always_comb begin
    inc    = sum[1] & (sum[0] | sticky | sum[2]);
    rnd    = {1'b0, sum[25:2]} + {24'b0, inc};
    r_exp  = exp_w + {8'b0, rnd[24]};
    r_frac = rnd[24] ? rnd[23:1] : rnd[22:0];
  end

  // Operation sequencer with registered handshake, result and Adder drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      op_a          <= '0;
      op_b          <= '0;
      sa            <= 1'b0;
      sb            <= 1'b0;
      ea            <= '0;
      eb            <= '0;
      ma            <= '0;
      mb            <= '0;
      sticky        <= 1'b0;
      exp_w         <= '0;
      sum           <= '0;
      sgn           <= 1'b0;
      res_w         <= '0;
      ovf_w         <= 1'b0;
      inv_w         <= 1'b0;
      SignoA_o      <= 1'b0;
      SignoB_o      <= 1'b0;
      Mantissa_A_o  <= '0;
      Mantissa_B_o  <= '0;
      bus.Ocupado   <= 1'b0;
      bus.Valido    <= 1'b0;
      bus.Resultado <= '0;
      bus.Overflow  <= 1'b0;
      bus.Invalido  <= 1'b0;
    end else begin
      bus.Valido <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Inicio) begin
            op_a        <= bus.Op_A;
            op_b        <= bus.Op_B;
            bus.Ocupado <= 1'b1;
            state       <= UNPACK;
          end
        end
        UNPACK: begin
          sa <= op_a[31];
          sb <= op_b[31];
          ea <= op_a[30:23];
          eb <= op_b[30:23];
          ma <= {1'b1, op_a[22:0], 2'b00};
          mb <= {1'b1, op_b[22:0], 2'b00};
          if (special) begin
            res_w <= spec_res;
            inv_w <= spec_inv;
            ovf_w <= 1'b0;
            state <= DONE;
          end else begin
            state <= ALIGN;
          end
        end
        ALIGN: begin
          Mantissa_A_o <= a_big ? ma : mb;
          SignoA_o     <= a_big ? sa : sb;
          Mantissa_B_o <= al_mant;
          SignoB_o     <= a_big ? sb : sa;
          sticky       <= al_sticky;
          exp_w        <= {1'b0, a_big ? ea : eb};
          state        <= ADD;
        end
        ADD: begin
          sum   <= Suma_resul_i;
          sgn   <= Signo_sum_i;
          state <= NORM;
        end
        NORM: begin
          if (sum == '0) begin
            res_w <= '0;
            ovf_w <= 1'b0;
            inv_w <= 1'b0;
            state <= DONE;
          end else if (sum[26]) begin
            sum    <= {1'b0, sum[26:1]};
            sticky <= sticky | sum[0];
            exp_w  <= exp_w + 9'd1;
            state  <= ROUND;
          end else if (sum[25]) begin
            state <= ROUND;
          end else if (exp_w <= 9'd1) begin
            // the next left shift would take the exponent to 0: flush
            res_w <= {sgn, 31'b0};
            ovf_w <= 1'b0;
            inv_w <= 1'b0;
            state <= DONE;
          end else begin
            sum   <= {sum[25:0], 1'b0};
            exp_w <= exp_w - 9'd1;
          end
        end
        ROUND: begin
          inv_w <= 1'b0;
          if (r_exp >= 9'd255) begin
            res_w <= {sgn, 8'hFF, 23'b0};
            ovf_w <= 1'b1;
          end else begin
            res_w <= {sgn, r_exp[7:0], r_frac};
            ovf_w <= 1'b0;
          end
          state <= DONE;
        end
        DONE: begin
          bus.Resultado <= res_w;
          bus.Overflow  <= ovf_w;
          bus.Invalido  <= inv_w;
          bus.Valido    <= 1'b1;
          bus.Ocupado   <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Self-checking bench for fp_add_sequencer with a behavioural sign-magnitude Adder
// and an exact-integer IEEE-754 reference adder.
`timescale 1ns/1ps
module tb_fp_add_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        signo_a, signo_b, signo_sum;
  logic [25:0] mant_a, mant_b;
  logic [26:0] suma;

  int pass_cnt = 0;
  int total_cnt = 0;

  fp_add_sequencer_if bus ();

  fp_add_sequencer #(.NAN_CANON(32'h7FC00000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .SignoA_o     (signo_a),
    .SignoB_o     (signo_b),
    .Mantissa_A_o (mant_a),
    .Mantissa_B_o (mant_b),
    .Suma_resul_i (suma),
    .Signo_sum_i  (signo_sum)
  );

  always #5 clk = ~clk;

  // Sign-magnitude mantissa Adder
  always_comb begin
    if (signo_a == signo_b) begin
      suma      = {1'b0, mant_a} + {1'b0, mant_b};
      signo_sum = signo_a;
    end else if (mant_a >= mant_b) begin
      suma      = {1'b0, mant_a - mant_b};
      signo_sum = signo_a;
    end else begin
      suma      = {1'b0, mant_b - mant_a};
      signo_sum = signo_b;
    end
  end

  // Reference: exact integer sum of the two values, then one RNE rounding.
  // Exact for same-sign sums and for opposite-sign sums with exponent gap <= 2
  // (the only cases the random stimulus produces), plus all specials.
  function automatic void ref_add(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ovf, output logic inv);
    int ea, eb, e_lo, p, sh, ee;
    logic sa, sb, s;
    logic [127:0] xa, xb, big, q, rem, half;
    sa = a[31]; sb = b[31];
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    ovf = 1'b0; inv = 1'b0; r = '0;
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) begin
      r = 32'h7FC00000; inv = 1'b1;
    end else if (ea == 255 && eb == 255 && sa != sb) begin
      r = 32'h7FC00000; inv = 1'b1;
    end else if (ea == 255) begin
      r = a;
    end else if (eb == 255) begin
      r = b;
    end else if (ea == 0 && eb == 0) begin
      r = {sa & sb, 31'b0};
    end else if (ea == 0) begin
      r = b;
    end else if (eb == 0) begin
      r = a;
    end else begin
      e_lo = (ea < eb) ? ea : eb;
      xa = {104'b0, 1'b1, a[22:0]} << (ea - e_lo);
      xb = {104'b0, 1'b1, b[22:0]} << (eb - e_lo);
      if (sa == sb) begin big = xa + xb; s = sa; end
      else if (xa >= xb) begin big = xa - xb; s = sa; end
      else begin big = xb - xa; s = sb; end
      if (big == 0) begin
        r = '0;
      end else begin
        p = 0;
        for (int i = 0; i < 128; i++) if (big[i]) p = i;
        ee = e_lo + p - 23;
        if (p > 23) begin
          sh   = p - 23;
          q    = big >> sh;
          rem  = big & ((128'd1 << sh) - 128'd1);
          half = 128'd1 << (sh - 1);
          if (rem > half || (rem == half && q[0])) q = q + 128'd1;
          if (q == (128'd1 << 24)) begin q = q >> 1; ee = ee + 1; end
        end else begin
          q = big << (23 - p);
        end
        if (ee >= 255) begin
          r = {s, 8'hFF, 23'b0}; ovf = 1'b1;
        end else if (ee <= 0) begin
          r = {s, 31'b0};
        end else begin
          r = {s, ee[7:0], q[22:0]};
        end
      end
    end
  endfunction

  // Issue one operation; lat = edges from the capture edge to the Valido cycle, -1 on timeout
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic ovf, output logic inv, output int lat);
    @(negedge clk);
    bus.Inicio = 1'b1; bus.Op_A = a; bus.Op_B = b;
    @(posedge clk); #1;
    bus.Inicio = 1'b0; bus.Op_A = $urandom; bus.Op_B = $urandom;
    lat = -1;
    for (int n = 1; n <= 60 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (bus.Valido) lat = n;
    end
    r = bus.Resultado; ovf = bus.Overflow; inv = bus.Invalido;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total_cnt++; if (bus.Ocupado !== 1'b0) $display("FAIL reset_ocupado got=%b exp=0", bus.Ocupado); else pass_cnt++;
    total_cnt++; if (bus.Valido !== 1'b0) $display("FAIL reset_valido got=%b exp=0", bus.Valido); else pass_cnt++;
    total_cnt++; if (bus.Resultado !== 32'h0) $display("FAIL reset_resultado got=%h exp=0", bus.Resultado); else pass_cnt++;
    total_cnt++; if ({bus.Overflow, bus.Invalido} !== 2'b00) $display("FAIL reset_flags got=%b exp=00", {bus.Overflow, bus.Invalido}); else pass_cnt++;
    total_cnt++; if ({signo_a, signo_b, mant_a, mant_b} !== 54'h0) $display("FAIL reset_adder_drive got=%h exp=0", {signo_a, signo_b, mant_a, mant_b}); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  typedef struct {
    logic [31:0] a, b, r;
    logic        ovf, inv;
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t v[$];
    logic [31:0] r; logic ovf, inv; int lat;
    v.push_back('{32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 6});
    v.push_back('{32'h3F800000, 32'hBF400000, 32'h3E800000, 1'b0, 1'b0, 8});
    v.push_back('{32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0, 1'b0, 6});
    v.push_back('{32'h3F800000, 32'h33800001, 32'h3F800001, 1'b0, 1'b0, 6});
    v.push_back('{32'h33800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 6});
    v.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1, 1'b0, 6});
    v.push_back('{32'h40490FDB, 32'hC0490FDB, 32'h00000000, 1'b0, 1'b0, -1});
    v.push_back('{32'h00800000, 32'h80C00000, 32'h80000000, 1'b0, 1'b0, -1});
    v.push_back('{32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 1'b1, 2});
    v.push_back('{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b1, 2});
    v.push_back('{32'h80000000, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 2});
    v.push_back('{32'h00000000, 32'hC0490FDB, 32'hC0490FDB, 1'b0, 1'b0, 2});
    v.push_back('{32'h40000000, 32'hFF800000, 32'hFF800000, 1'b0, 1'b0, 2});
    foreach (v[i]) begin
      run_op(v[i].a, v[i].b, r, ovf, inv, lat);
      total_cnt++;
      if (r !== v[i].r) $display("FAIL dir%0d_result %h+%h got=%h exp=%h", i, v[i].a, v[i].b, r, v[i].r); else pass_cnt++;
      total_cnt++;
      if ({ovf, inv} !== {v[i].ovf, v[i].inv}) $display("FAIL dir%0d_flags got=%b exp=%b", i, {ovf, inv}, {v[i].ovf, v[i].inv}); else pass_cnt++;
      total_cnt++;
      if (v[i].lat >= 0 ? (lat != v[i].lat) : (lat < 0)) $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, v[i].lat); else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, r, er; logic ovf, inv, eovf, einv; int lat, kind, ea, eb, elat;
    logic [31:0] spec[6];
    spec[0] = 32'h7F800000; spec[1] = 32'hFF800000; spec[2] = 32'h7FC12345;
    spec[3] = 32'h00000000; spec[4] = 32'h80000000; spec[5] = 32'h00012345;
    for (int it = 0; it < 150; it++) begin
      kind = int'($urandom_range(0, 9));
      ea = int'($urandom_range(40, 200));
      a = {1'($urandom), ea[7:0], 23'($urandom)};
      if (kind == 0) begin
        b = spec[$urandom_range(0, 5)];
        if ($urandom_range(0, 1) == 1) begin b = a; a = spec[$urandom_range(0, 5)]; end
        elat = 2;
      end else if (kind <= 5) begin
        eb = ea - 20 + int'($urandom_range(0, 40));
        b = {a[31], eb[7:0], 23'($urandom)};
        elat = 6;
      end else begin
        eb = ea - 2 + int'($urandom_range(0, 4));
        b = {~a[31], eb[7:0], 23'($urandom)};
        elat = -1;
      end
      ref_add(a, b, er, eovf, einv);
      run_op(a, b, r, ovf, inv, lat);
      total_cnt++;
      if ({r, ovf, inv} !== {er, eovf, einv}) $display("FAIL rand%0d %h+%h got=%h/%b%b exp=%h/%b%b", it, a, b, r, ovf, inv, er, eovf, einv); else pass_cnt++;
      total_cnt++;
      if (elat >= 0 ? (lat != elat) : (lat < 0)) $display("FAIL rand%0d_latency got=%0d exp=%0d", it, lat, elat); else pass_cnt++;
    end
  endtask

  task automatic test_handshake();
    logic [31:0] r, held; logic ovf, inv; int lat;
    @(negedge clk);
    bus.Inicio = 1'b1; bus.Op_A = 32'h3F800000; bus.Op_B = 32'h3F800000;
    @(posedge clk); #1;
    bus.Inicio = 1'b0;
    total_cnt++; if (bus.Ocupado !== 1'b1) $display("FAIL busy_after_capture got=%b exp=1", bus.Ocupado); else pass_cnt++;
    lat = -1;
    for (int n = 1; n <= 60 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (bus.Valido) lat = n;
    end
    total_cnt++; if (bus.Ocupado !== 1'b0) $display("FAIL busy_at_valid got=%b exp=0", bus.Ocupado); else pass_cnt++;
    held = bus.Resultado;
    @(posedge clk); #1;
    total_cnt++; if (bus.Valido !== 1'b0) $display("FAIL valid_one_cycle got=%b exp=0", bus.Valido); else pass_cnt++;
    repeat (4) @(posedge clk); #1;
    total_cnt++; if (bus.Resultado !== 32'h40000000 || held !== 32'h40000000) $display("FAIL result_held got=%h exp=40000000", bus.Resultado); else pass_cnt++;
    // back-to-back: second start lands in the Valido cycle of the first
    run_op(32'h40000000, 32'h40000000, r, ovf, inv, lat);
    run_op(32'h3F800000, 32'hBF400000, r, ovf, inv, lat);
    total_cnt++; if (r !== 32'h3E800000 || lat != 8) $display("FAIL back_to_back got=%h/%0d exp=3e800000/8", r, lat); else pass_cnt++;
  endtask

  task automatic test_busy_ignore();
    int vcnt; logic [31:0] r; logic inv;
    vcnt = 0; r = '0; inv = 1'b0;
    @(negedge clk);
    bus.Inicio = 1'b1; bus.Op_A = 32'h3F800000; bus.Op_B = 32'h3F800000;
    @(posedge clk); #1;
    bus.Inicio = 1'b0;
    @(negedge clk);
    bus.Inicio = 1'b1; bus.Op_A = 32'h7FC00000; bus.Op_B = 32'h3F800000;
    repeat (3) @(negedge clk);
    bus.Inicio = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (bus.Valido) begin vcnt++; r = bus.Resultado; inv = bus.Invalido; end
    end
    total_cnt++; if (vcnt != 1) $display("FAIL busy_ignore_count got=%0d exp=1", vcnt); else pass_cnt++;
    total_cnt++; if (r !== 32'h40000000 || inv !== 1'b0) $display("FAIL busy_ignore_result got=%h/%b exp=40000000/0", r, inv); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int vcnt; logic [31:0] r; logic ovf, inv; int lat;
    vcnt = 0;
    @(negedge clk);
    bus.Inicio = 1'b1; bus.Op_A = 32'h3F800000; bus.Op_B = 32'hBF400000;
    @(posedge clk); #1;
    bus.Inicio = 1'b0;
    repeat (4) @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total_cnt++; if ({bus.Ocupado, bus.Valido, bus.Overflow, bus.Invalido} !== 4'b0) $display("FAIL midreset_ctrl got=%b exp=0000", {bus.Ocupado, bus.Valido, bus.Overflow, bus.Invalido}); else pass_cnt++;
    total_cnt++; if (bus.Resultado !== 32'h0 || mant_a !== 26'h0 || mant_b !== 26'h0) $display("FAIL midreset_data got=%h/%h/%h exp=0", bus.Resultado, mant_a, mant_b); else pass_cnt++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk); #1;
      if (bus.Valido) vcnt++;
    end
    total_cnt++; if (vcnt != 0) $display("FAIL midreset_no_valid got=%0d exp=0", vcnt); else pass_cnt++;
    run_op(32'h3F800000, 32'h3F800000, r, ovf, inv, lat);
    total_cnt++; if (r !== 32'h40000000 || lat != 6) $display("FAIL after_reset got=%h/%0d exp=40000000/6", r, lat); else pass_cnt++;
  endtask

  initial begin
    bus.Inicio = 1'b0; bus.Op_A = '0; bus.Op_B = '0;
    test_reset();
    test_directed();
    test_random();
    test_handshake();
    test_busy_ignore();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fp_add_sequencer.md
Name: fp_add_sequencer

Overview:
- Multi-cycle IEEE-754 single-precision add/subtract controller.
- Sequences the shared mantissa Adder datapath (sign-magnitude add/sub of 26-bit mantissas, 27-bit result plus sign) through unpack, align, add, normalize, round and pack.
- Sits between the operand source and the Adder instance.
- Owns the start/busy/valid handshake, special-value handling and all exponent bookkeeping.

Parameters:
- NAN_CANON, 32'h7FC00000, canonical quiet NaN returned for invalid operations and NaN inputs.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- Inicio  in  1  start request; sampled only in IDLE
- Op_A  in  32  operand A, IEEE-754 single
- Op_B  in  32  operand B, IEEE-754 single
- Ocupado  out  1  high while an operation is in flight (any state except IDLE)
- Valido  out  1  one-cycle pulse: Resultado and flags are valid
- Resultado  out  32  packed result; held from Valido until the next capture
- Overflow  out  1  result rounded to infinity from finite operands; held like Resultado
- Invalido  out  1  NaN input or Inf + (-Inf); held like Resultado
- SignoA_o  out  1  sign to Adder port A
- SignoB_o  out  1  sign to Adder port B
- Mantissa_A_o  out  26  {hidden,frac[22:0],G,R} to Adder A
- Mantissa_B_o  out  26  aligned mantissa to Adder B
- Suma_resul_i  in  27  Adder magnitude result
- Signo_sum_i  in  1  Adder result sign

Behaviour:
- Reset:
  - State IDLE.
  - Ocupado, Valido, Overflow and Invalido are 0.
  - Resultado, all Adder drive outputs and internal registers are 0.
  - Reset mid-operation aborts the operation; no Valido is produced.
- State sequence: IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> DONE -> IDLE.
- IDLE:
  - When Inicio=1, latch Op_A and Op_B and go to UNPACK.
  - Inicio is ignored while Ocupado=1; operand changes after capture have no effect.
- UNPACK:
  - Split each operand into sign, exponent and fraction.
  - Exponent 0 (zero or denormal) is flushed to signed zero.
  - Specials go directly to DONE:
    - Any NaN -> NAN_CANON, Invalido=1.
    - Inf + (-Inf) -> NAN_CANON, Invalido=1.
    - Inf with finite or same-sign Inf -> that Inf.
    - Both zero -> +0, except (-0)+(-0) -> -0.
    - One zero -> the other operand unchanged.
  - Otherwise form mantissa = {1,frac,2'b00}.
- ALIGN:
  - Operand with the larger exponent (A on tie) drives Mantissa_A_o and SignoA_o.
  - The other mantissa is shifted right by d = exponent difference in a single cycle.
  - Bits shifted out are ORed into a sticky register; if d >= 26 the mantissa becomes 0 and sticky = OR of the original mantissa.
  - Working exponent = the larger exponent.
- ADD: register Suma_resul_i and Signo_sum_i. Adder outputs are combinational; Adder inputs stay stable through this cycle.
- NORM:
  - Sum == 0 -> result +0 (any sticky is discarded); go to DONE.
  - sum[26]=1 -> shift right 1, sticky |= sum[0], exponent+1; 1 cycle, then ROUND.
  - Else while sum[25]=0: shift left 1, exponent-1, one cycle per bit.
  - If the exponent reaches 0 -> flush to signed zero, go to DONE.
  - NORM always takes at least 1 cycle.
- ROUND:
  - Round to nearest, ties to even.
  - Bits: LSB=sum[2], G=sum[1], R=sum[0], S=sticky.
  - Increment when G & (R|S|LSB).
  - Carry into bit 26 -> mantissa shifts right, exponent+1.
  - Exponent >= 255 -> ±Inf with Overflow=1.
- DONE: Valido=1 for exactly one cycle, Resultado and flags updated in this same cycle, then IDLE.
- Latency, counted in rising edges from the edge that samples Inicio to the Valido cycle:
  - Specials: 2.
  - Normal path: 6 + k, where k = number of left-normalization shifts (k <= 25).
  - Back-to-back: Inicio may be asserted in the cycle after Valido.
- Ocupado: rises on the capture edge, falls on the edge leaving DONE.

Test Plan:
- 0x3F800000 + 0x3F800000 -> Resultado 0x40000000, Valido exactly 6 edges after Inicio, flags 0.
- 0x3F800000 + 0xBF400000 (1.0 - 0.75) -> 0x3E800000, Valido at edge 8 (k=2).
- Tie and sticky rounding: 0x3F800000 + 0x33800000 -> 0x3F800000 (tie to even); 0x3F800000 + 0x33800001 -> 0x3F800001.
- Overflow and cancellation: 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, Overflow=1; 0x40490FDB + 0xC0490FDB -> 0x00000000.
- Specials:
  - 0x7F800000 + 0xFF800000 -> 0x7FC00000, Invalido=1, Valido at edge 2.
  - 0x7FC00001 + 0x3F800000 -> 0x7FC00000, Invalido=1.
  - 0x80000000 + 0x80000000 -> 0x80000000.
- Control:
  - Pulse Inicio again while Ocupado=1 -> ignored; exactly one Valido with the first result.
  - Drop rst_n during NORM -> all outputs 0 immediately, no Valido.
  - A new Inicio after reset completes normally.
